// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch stage: widths, reset defaults, NOP
// encoding, fetch-state encoding and base opcodes.
package rv32i_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [2:0] {
        FS_RESET = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_VALID = 3'd3,
        FS_HALT  = 3'd4
    } fetch_state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    function automatic logic [6:0] get_opcode(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid handshake between the fetch unit (master)
// and the instruction memory (slave).
interface instr_fetch_unit_if #(
    parameter int XLEN = rv32i_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC arithmetic: pc+4 or pc+ImmExt, with alignment handling selected by
// MISALIGN_TRAP_EN (flag a misaligned taken target, or force bits [1:0] to zero).
module pc_next_calc #(
    parameter int XLEN = rv32i_pkg::XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            misaligned
`endif
);
    logic [XLEN-1:0] target;

    // Both sums wrap modulo 2^XLEN.
    assign pc_plus4 = pc + XLEN'(4);
    assign target   = pcsrc ? (pc + imm_ext) : pc_plus4;

`ifdef MISALIGN_TRAP_EN
    assign next_pc    = target;
    assign misaligned = pcsrc & (|target[1:0]);
`else
    assign next_pc    = target & ~XLEN'(3);
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, one-at-a-time instruction fetch over req/gnt/rvalid,
// holds the instruction for decode until retire. Optional macro: MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter int              XLEN     = rv32i_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(rv32i_pkg::RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  imem,
    output logic [XLEN-1:0]     instr,
    output logic                instr_valid,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    input  logic                ex_ready,
    input  logic                PCsrc,
    input  logic [XLEN-1:0]     ImmExt,
    output logic                misalign_trap
);
    import rv32i_pkg::*;

    fetch_state_e    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] instr_reg, instr_next;
    logic            instr_valid_reg, instr_valid_next;
    logic [XLEN-1:0] calc_pc;
`ifdef MISALIGN_TRAP_EN
    logic            trap_reg, trap_next;
    logic            calc_misaligned;
`endif

    pc_next_calc #(.XLEN(XLEN)) u_pc_next_calc (
        .pc         (pc_reg),
        .pcsrc      (PCsrc),
        .imm_ext    (ImmExt),
        .pc_plus4   (pc_plus4),
        .next_pc    (calc_pc)
`ifdef MISALIGN_TRAP_EN
        ,
        .misaligned (calc_misaligned)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= FS_RESET;
            pc_reg          <= RESET_PC;
            instr_reg       <= XLEN'(NOP_INSTR);
            instr_valid_reg <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            trap_reg        <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            instr_valid_reg <= instr_valid_next;
`ifdef MISALIGN_TRAP_EN
            trap_reg        <= trap_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instr_next       = instr_reg;
        instr_valid_next = instr_valid_reg;
`ifdef MISALIGN_TRAP_EN
        trap_next        = trap_reg;
`endif
        case (state_reg)
            FS_RESET: state_next = FS_REQ;
            FS_REQ: begin
                if (imem.imem_gnt) begin
                    if (imem.imem_rvalid) begin
                        instr_next       = imem.imem_rdata;
                        instr_valid_next = 1'b1;
                        state_next       = FS_VALID;
                    end else begin
                        state_next = FS_WAIT;
                    end
                end
            end
            FS_WAIT: begin
                if (imem.imem_rvalid) begin
                    instr_next       = imem.imem_rdata;
                    instr_valid_next = 1'b1;
                    state_next       = FS_VALID;
                end
            end
            FS_VALID: begin
                // PCsrc/ImmExt only matter on the retiring cycle.
                if (ex_ready) begin
                    pc_next          = calc_pc;
                    instr_valid_next = 1'b0;
                    state_next       = FS_REQ;
`ifdef MISALIGN_TRAP_EN
                    if (calc_misaligned) begin
                        trap_next  = 1'b1;
                        state_next = FS_HALT;
                    end
`endif
                end
            end
`ifdef MISALIGN_TRAP_EN
            FS_HALT: state_next = FS_HALT;
`endif
            default: state_next = FS_RESET;
        endcase
    end

    assign imem.imem_req  = (state_reg == FS_REQ);
    assign imem.imem_addr = pc_reg;
    assign instr          = instr_reg;
    assign instr_valid    = instr_valid_reg;
    assign pc             = pc_reg;
`ifdef MISALIGN_TRAP_EN
    assign misalign_trap  = trap_reg;
`else
    assign misalign_trap  = 1'b0;
`endif

endmodule
